// File: rtl/hwpe_stream_package.sv
// Shared TCDM widths and the response-pipe payload used by the TCDM responder.
package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_TCDM_DW = 32;
    localparam int unsigned HWPE_STREAM_TCDM_BE = 4;

    typedef struct packed {
        logic                           valid;
        logic [HWPE_STREAM_TCDM_DW-1:0] data;
    } tcdm_resp_pipe_t;

endpackage

// File: rtl/hwpe_stream_tcdm_resp_pipe.sv
// Fixed-latency response pipe: LATENCY-deep shift register of {valid, data}.
// Stage 0 loads every cycle; rst_i or clear_i flushes all in-flight responses.
module hwpe_stream_tcdm_resp_pipe
    import hwpe_stream_package::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           valid_i,
    input  logic [HWPE_STREAM_TCDM_DW-1:0] data_i,
    output logic                           valid_o,
    output logic [HWPE_STREAM_TCDM_DW-1:0] data_o
);

    tcdm_resp_pipe_t [LATENCY-1:0] pipe_q;
    tcdm_resp_pipe_t [LATENCY-1:0] pipe_d;

    // Shift by one stage; data is forced to zero for empty slots.
    always_comb begin
        pipe_d            = pipe_q;
        pipe_d[0].valid   = valid_i;
        pipe_d[0].data    = valid_i ? data_i : '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe register with synchronous flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_o = pipe_q[LATENCY-1].valid;
    assign data_o  = pipe_q[LATENCY-1].data;

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// Single-bank TCDM target: word scratchpad with byte-strobed writes and a
// fixed-latency in-order response path. Optional pseudo-random grant stalls
// are enabled by defining HWPE_STREAM_TCDM_RESPONDER_STALL_EN.
module hwpe_stream_tcdm_responder
    import hwpe_stream_package::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           req_i,
    output logic                           gnt_o,
    input  logic [31:0]                    add_i,
    input  logic                           wen_i,
    input  logic [HWPE_STREAM_TCDM_BE-1:0] be_i,
    input  logic [HWPE_STREAM_TCDM_DW-1:0] data_i,
    output logic                           r_valid_o,
    output logic [HWPE_STREAM_TCDM_DW-1:0] r_data_o,
    output logic                           err_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    logic [HWPE_STREAM_TCDM_DW-1:0] mem_q [DEPTH];
    logic [31:0]                    off_c;
    logic [AW-1:0]                  idx_c;
    logic                           in_range_c;
    logic                           stall_c;
    logic                           hs_c;
    logic [HWPE_STREAM_TCDM_DW-1:0] rdata_c;
    logic                           err_q;

`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR keeps running through clear_i; only rst_i reseeds it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_c = req_i & lfsr_q[0] & lfsr_q[1];
`else
    logic unused_seed;
    assign unused_seed = ^STALL_SEED;
    assign stall_c     = 1'b0;
`endif

    // Address decode relative to BASE_ADDR; wrap-around catches below-base accesses.
    assign off_c      = add_i - BASE_ADDR;
    assign idx_c      = off_c[AW+1:2];
    assign in_range_c = (off_c < SPAN);

    assign gnt_o   = req_i & ~stall_c & ~rst_i;
    assign hs_c    = req_i & gnt_o;
    assign rdata_c = (wen_i && in_range_c) ? mem_q[idx_c] : '0;

    // Byte-strobed write port; array content is never reset.
    always_ff @(posedge clk_i) begin
        if (hs_c && !wen_i && in_range_c) begin
            for (int unsigned b = 0; b < HWPE_STREAM_TCDM_BE; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_c][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    // Sticky out-of-range flag.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            err_q <= 1'b0;
        end else if (hs_c && !in_range_c) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    hwpe_stream_tcdm_resp_pipe #(
        .LATENCY (LATENCY)
    ) i_resp_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .valid_i (hs_c),
        .data_i  (rdata_c),
        .valid_o (r_valid_o),
        .data_o  (r_data_o)
    );

endmodule
